mem_port_sequencer: RTL
=======================

Name: mem_port_sequencer

Overview:
- Multi-cycle sequencer for a RISC-V core whose instruction and data accesses share one single-ported memory with a ready handshake.
- Steps each instruction through fetch, decode, optional data access and commit.
- Takes memRead/memWrite/regWrite from the control unit and produces the memory request, address select, and register/PC write enables.
- Sits between the control unit, the PC/IR/MDR registers and the memory.

Parameters:
TIMEOUT, 16, max cycles a memory request may wait for mem_ready before error (≥1)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
ctrl_mem_read  in  1  memRead from control unit (decoded from current IR)
ctrl_mem_write  in  1  memWrite from control unit
ctrl_reg_write  in  1  regWrite from control unit
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request valid
mem_we  out  1  request is a write (valid only with mem_req)
addr_sel  out  1  0 = PC drives memory address, 1 = ALU result
ir_load  out  1  load IR from memory read data this cycle
mdr_load  out  1  load MDR from memory read data this cycle
pc_write_en  out  1  PC update (next-PC mux) this cycle
rf_write_en  out  1  register-file write this cycle
err  out  1  sticky: timeout or read+write conflict
retired  out  CNT_W  count of committed instructions

Behaviour:
- Reset (async, rst_n=0): state=FETCH, wait counter=0, err=0, retired=0. All outputs except retired/err are decoded from state; during reset they hold FETCH-state values gated off, so every output is 0. First request is issued in the first cycle after rst_n rises.
- States: FETCH, DECODE, DATA, COMMIT, HALT.
- FETCH:
  - mem_req=1, mem_we=0, addr_sel=0.
  - If mem_ready=1: ir_load=1 (Mealy, same cycle) and go to DECODE; else stay.
- DECODE:
  - One cycle; all enables 0; control inputs sampled this cycle.
  - ctrl_mem_read=1 and ctrl_mem_write=1 together: set err and go to HALT.
  - Either one set: go to DATA.
  - Neither set: go to COMMIT.
  - The read/write choice is latched into a 1-bit register and used throughout DATA.
- DATA:
  - mem_req=1, addr_sel=1, mem_we = latched write flag.
  - On mem_ready=1: mdr_load=1 only if latched read; go to COMMIT.
- COMMIT:
  - pc_write_en=1 and rf_write_en=ctrl_reg_write for exactly one cycle.
  - retired increments by 1, wrapping modulo 2^CNT_W.
  - Next state is FETCH.
- HALT:
  - All enables 0 and mem_req=0; err=1 held. Exited only by reset.
- Timeout:
  - The wait counter clears on entry to FETCH or DATA and increments on each request cycle with mem_ready=0.
  - If it reaches TIMEOUT-1 with mem_ready still 0, set err and go to HALT on the next edge; the request drops.
  - mem_ready arriving in that same cycle wins: normal completion, no error.
- mem_ready outside FETCH/DATA is ignored.
- Latency with zero-wait memory (mem_ready high on the first request cycle):
  - non-memory instruction: 3 cycles;
  - load/store: 4 cycles.
  - Each wait cycle adds 1.
- At most one of ir_load/mdr_load/pc_write_en is ever high in any cycle.
- Reset mid-request drops mem_req asynchronously; no partial commit occurs.

Test Plan:
- R-type with mem_ready tied 1 (read=0, write=0, reg_write=1) → FETCH/DECODE/COMMIT repeat every 3 cycles; ir_load then pc_write_en+rf_write_en; retired=3 after 9 cycles.
- Load with mem_ready tied 1 (read=1, reg_write=1) → 4-cycle loop; DATA cycle shows addr_sel=1, mem_we=0, mdr_load=1; COMMIT rf_write_en=1.
- Store (write=1, reg_write=0) with mem_ready delayed 2 cycles in DATA → DATA lasts 3 cycles with mem_we=1 and mdr_load=0; COMMIT rf_write_en=0; instruction takes 6 cycles.
- TIMEOUT=4, mem_ready never asserted in FETCH → mem_req high 4 cycles, then err=1, state HALT, all enables 0 until rst_n pulse; retired unchanged.
- TIMEOUT=4, mem_ready in 4th wait cycle → normal completion, err=0.
- Read and write both 1 in DECODE → err=1, HALT, no mem_req.
- Reset during DATA → outputs 0 immediately; after release, FETCH with retired=0.
- CNT_W=4, 16 commits → retired wraps to 0.

Source files
------------

// File: rtl/mem_port_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_sequencer
//  Description : Multi-cycle instruction sequencer for a RISC-V core whose
//                instruction fetches and data accesses share one single-ported
//                memory with a ready handshake.  Each instruction is stepped
//                through FETCH -> DECODE -> [DATA] -> COMMIT.  A memory request
//                that waits TIMEOUT cycles without mem_ready, or a decoded
//                instruction asking for both read and write, parks the
//                sequencer in HALT with a sticky error until reset.
//
//  Ports       : clk            - clock, all state on rising edge
//                rst_n          - asynchronous active-low reset
//                ctrl_mem_read  - memRead from control unit (current IR)
//                ctrl_mem_write - memWrite from control unit
//                ctrl_reg_write - regWrite from control unit
//                mem_ready      - memory completes current request this cycle
//                mem_req        - memory request valid
//                mem_we         - request is a write
//                addr_sel       - 0 = PC addresses memory, 1 = ALU result
//                ir_load        - capture memory read data into IR
//                mdr_load       - capture memory read data into MDR
//                pc_write_en    - PC update this cycle
//                rf_write_en    - register-file write this cycle
//                err            - sticky timeout / read+write conflict flag
//                retired        - committed-instruction count (wraps)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ctrl_mem_read,
    input  logic             ctrl_mem_write,
    input  logic             ctrl_reg_write,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_load,
    output logic             mdr_load,
    output logic             pc_write_en,
    output logic             rf_write_en,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    // Wait counter only needs to reach TIMEOUT-1.
    localparam int                WAIT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_DATA   = 3'd2,
        S_COMMIT = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WAIT_W-1:0] r_wait;
    logic              r_is_write;   // latched in DECODE, steers the DATA access
    logic              r_err;
    logic [CNT_W-1:0]  r_retired;

    logic w_wait_last;
    logic w_req;
    logic w_we;
    logic w_addr_sel;
    logic w_ir_load;
    logic w_mdr_load;
    logic w_pc_write;
    logic w_rf_write;
    logic w_set_err;

    assign w_wait_last = (r_wait == C_WAIT_LAST);

    // ------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_we         = 1'b0;
        w_addr_sel   = 1'b0;
        w_ir_load    = 1'b0;
        w_mdr_load   = 1'b0;
        w_pc_write   = 1'b0;
        w_rf_write   = 1'b0;
        w_set_err    = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_req = 1'b1;
                // A ready arriving on the last allowed wait cycle still wins.
                if (mem_ready) begin
                    w_ir_load    = 1'b1;
                    w_state_next = S_DECODE;
                end else if (w_wait_last) begin
                    w_set_err    = 1'b1;
                    w_state_next = S_HALT;
                end
            end
            S_DECODE: begin
                if (ctrl_mem_read && ctrl_mem_write) begin
                    w_set_err    = 1'b1;
                    w_state_next = S_HALT;
                end else if (ctrl_mem_read || ctrl_mem_write) begin
                    w_state_next = S_DATA;
                end else begin
                    w_state_next = S_COMMIT;
                end
            end
            S_DATA: begin
                w_req      = 1'b1;
                w_addr_sel = 1'b1;
                w_we       = r_is_write;
                if (mem_ready) begin
                    w_mdr_load   = ~r_is_write;
                    w_state_next = S_COMMIT;
                end else if (w_wait_last) begin
                    w_set_err    = 1'b1;
                    w_state_next = S_HALT;
                end
            end
            S_COMMIT: begin
                w_pc_write   = 1'b1;
                w_rf_write   = ctrl_reg_write;
                w_state_next = S_FETCH;
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, wait counter, latched access type, error and retire count
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_wait     <= '0;
            r_is_write <= 1'b0;
            r_err      <= 1'b0;
            r_retired  <= '0;
        end else begin
            r_state <= w_state_next;

            // Any state change restarts the count, so entry to FETCH/DATA
            // always begins at zero.
            if (w_state_next != r_state) begin
                r_wait <= '0;
            end else if (w_req && !mem_ready) begin
                r_wait <= r_wait + WAIT_W'(1);
            end

            if (r_state == S_DECODE) begin
                r_is_write <= ctrl_mem_write;
            end

            if (w_set_err) begin
                r_err <= 1'b1;
            end

            if (r_state == S_COMMIT) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    // While reset is held the state register sits in FETCH; gating with
    // rst_n keeps every strobe low so a mid-request reset drops mem_req at once.
    assign mem_req     = rst_n & w_req;
    assign mem_we      = rst_n & w_we;
    assign addr_sel    = rst_n & w_addr_sel;
    assign ir_load     = rst_n & w_ir_load;
    assign mdr_load    = rst_n & w_mdr_load;
    assign pc_write_en = rst_n & w_pc_write;
    assign rf_write_en = rst_n & w_rf_write;
    assign err         = r_err;
    assign retired     = r_retired;

endmodule
`default_nettype wire
